// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MS digit first.
// Optional digit validity checking is enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  start,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for start; bin/err hold the last result
    // CONV  | consuming one digit per cycle from the shift register
    typedef enum logic {IDLE, CONV} state_t;

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SR_W  = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               done_q, done_d;
    logic [3:0]         digit;
    logic [BIN_W-1:0]   acc_step;
    logic               last;
`ifdef BCD2BIN_CHECK_EN
    logic               err_q, err_d;
    logic               errs_q, errs_d;
    logic               bad;
`endif

    always_comb begin
        digit    = sr_q[SR_W-1 -: 4];
        acc_step = acc_q * BIN_W'(10) + BIN_W'(digit);
        last     = (cnt_q == CNT_W'(DIGITS - 1));
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        done_d   = 1'b0;
`ifdef BCD2BIN_CHECK_EN
        bad      = (digit > 4'd9);
        err_d    = err_q;
        errs_d   = errs_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
`ifdef BCD2BIN_CHECK_EN
                    errs_d  = 1'b0;
`endif
                end
            end
            CONV: begin
                acc_d = acc_step;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef BCD2BIN_CHECK_EN
                errs_d = errs_q | bad;
`endif
                if (last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef BCD2BIN_CHECK_EN
                    // An invalid digit anywhere in the word poisons the result.
                    err_d = errs_q | bad;
                    bin_d = (errs_q | bad) ? '0 : acc_step;
`else
                    bin_d = acc_step;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            done_q  <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
            err_q   <= 1'b0;
            errs_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
`ifdef BCD2BIN_CHECK_EN
            err_q   <= err_d;
            errs_q  <= errs_d;
`endif
        end
    end

    assign bin  = bin_q;
    assign busy = (state_q == CONV);
    assign done = done_q;
`ifdef BCD2BIN_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin;

    logic        clk;
    logic        clr;
    logic [15:0] bcd;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [13:0] last_bin = '0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk   (clk),
        .clr   (clr),
        .bcd   (bcd),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and follow the conversion to its done cycle.
    task automatic run_conv(input logic [15:0] word, input logic [13:0] exp_bin, input logic exp_err);
        bcd   = word;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("conv_busy", 32'(busy), 32'd1);
            chk("conv_done_low", 32'(done), 32'd0);
            chk("conv_bin_hold", 32'(bin), 32'(last_bin));
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("result_bin", 32'(bin), 32'(exp_bin));
        chk("result_err", 32'(err), 32'(exp_err));
        last_bin = exp_bin;
    endtask

    initial begin
        clr   = 1'b0;
        start = 1'b0;
        bcd   = '0;
        #3;
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        #2 clr = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        run_conv(16'h1234, 14'd1234, 1'b0);
        tick();
        chk("done_drop", 32'(done), 32'd0);

        run_conv(16'h9999, 14'd9999, 1'b0);
        // Next start is presented in the done cycle: back-to-back.
        run_conv(16'h0000, 14'd0, 1'b0);
        tick();
        chk("b2b_done_drop", 32'(done), 32'd0);

`ifdef BCD2BIN_CHECK_EN
        run_conv(16'h12A4, 14'd0, 1'b1);
`else
        run_conv(16'h12A4, 14'd1304, 1'b0);
`endif
        tick();

        // Restart attempt and bcd change while busy must be ignored.
        bcd   = 16'h0042;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        bcd   = 16'h7777;
        tick();
        start = 1'b0;
        chk("ignore_busy", 32'(busy), 32'd1);
        chk("ignore_done_low", 32'(done), 32'd0);
        tick();
        chk("ignore_done", 32'(done), 32'd1);
        chk("ignore_bin", 32'(bin), 32'd42);
        chk("ignore_err", 32'(err), 32'd0);
        last_bin = 14'd42;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_second_busy", 32'(busy), 32'd0);
            chk("no_second_done", 32'(done), 32'd0);
            chk("no_second_bin", 32'(bin), 32'd42);
        end

        // Asynchronous reset mid-conversion.
        bcd   = 16'h3333;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 clr = 1'b0;
        #1;
        chk("aclr_bin", 32'(bin), 32'd0);
        chk("aclr_busy", 32'(busy), 32'd0);
        chk("aclr_done", 32'(done), 32'd0);
        chk("aclr_err", 32'(err), 32'd0);
        tick();
        #3 clr = 1'b1;
        last_bin = 14'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_clr_done", 32'(done), 32'd0);
            chk("post_clr_busy", 32'(busy), 32'd0);
            chk("post_clr_bin", 32'(bin), 32'd0);
        end

        run_conv(16'h0500, 14'd500, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_bin", 32'(bin), 32'd500);
            chk("hold_err", 32'(err), 32'd0);
            chk("hold_done", 32'(done), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential converter that turns a packed multi-digit BCD word, such as the value held by a cascade of BCD counters, back into a plain unsigned binary number. It is the decode end of the BCD count path. Downstream binary logic (comparators, timers, register files) uses it to consume counter values. It processes one BCD digit per clock, most-significant first, under a start/busy/done handshake.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits in the input word.
- BIN_W, 14: output width; must satisfy 2^BIN_W > 10^DIGITS − 1 (14 covers 9999).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset; asynchronous, active-low (clr = 0 resets immediately, independent of clk).
- bcd  input  4*DIGITS  packed BCD word; digit DIGITS−1 in the top nibble.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  output  BIN_W  binary result; holds until the next completed conversion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin/err are updated.
- err  output  1  invalid-digit flag for the last result (see Configuration).

## Operation
- States:
  - IDLE: busy=0.
  - CONV: busy=1.
- IDLE, start=1:
  - latch bcd into an internal digit shift register;
  - clear accumulator acc and digit counter cnt;
  - go to CONV.
- IDLE, start=0: hold all outputs; done=0.
- CONV, each cycle:
  - acc ← acc*10 + top digit (computed in BIN_W bits, modulo 2^BIN_W);
  - shift the digit register left by 4;
  - cnt ← cnt+1.
- CONV, on the cycle that consumes digit index 0 (cnt = DIGITS−1):
  - load bin with the final acc (or 0 on error, see Configuration) and update err;
  - pulse done=1;
  - return to IDLE.
- start while busy=1 is ignored; bcd changes after the start cycle have no effect on the conversion in progress.
- start=1 in the cycle where done=1 (state already IDLE) is accepted, so back-to-back conversions are allowed.
- Reset (clr=0) at any time:
  - bin=0, busy=0, done=0, err=0, state=IDLE, acc=0, cnt=0;
  - a conversion in progress is aborted with no done pulse.
- Undersized BIN_W is a configuration error and is not detected; the result wraps modulo 2^BIN_W.

## Timing
- start sampled high at rising edge k: busy=1 after edge k.
- Digits are consumed at edges k+1 … k+DIGITS.
- After edge k+DIGITS: done=1, bin/err valid, busy=0.
- After edge k+DIGITS+1: done=0 (unless a new conversion completes then, which is impossible for DIGITS ≥ 1).
- Latency is DIGITS+1 cycles from start to done; throughput is one result per DIGITS+1 cycles.
- All outputs are registered; none depends combinationally on inputs.

## Configuration
- Macro BCD2BIN_CHECK_EN, defined:
  - each digit is checked as it is consumed; any digit > 9 sets a sticky error for that conversion;
  - at completion err=1 and bin=0;
  - a clean conversion clears err.
- Macro not defined:
  - no checking; nibbles > 9 are weighted arithmetically (acc*10 + nibble);
  - err is tied to 0.

## Test plan
- Reset then DIGITS=4, bcd=16'h1234, start for one cycle -> busy high 4 cycles, done pulse on cycle 5 after start, bin=1234 (14'h04D2), err=0.
- bcd=16'h9999 -> bin=9999 (14'h270F); then bcd=16'h0000 issued with start in the done cycle -> second done exactly 5 cycles later, bin=0.
- bcd=16'h12A4:
  - with BCD2BIN_CHECK_EN: done with err=1, bin=0;
  - without it: bin=1304, err=0.
- start pulsed again 2 cycles into a conversion of 16'h0042, with bcd changed to 16'h7777 -> single done, bin=42; no second conversion begins.
- clr driven low mid-conversion (asynchronously, between edges) -> bin/busy/done/err drop to 0 immediately; no done pulse after clr releases; next start of 16'h0500 yields bin=500.
- Hold start=0 for 20 cycles after a conversion -> bin/err stable, done=0 throughout.
